// File: rtl/alert_pkg.sv
// Shared types and constants for the alert-panel status serial transmitter.
package alert_pkg;

   localparam int unsigned STATUS_W   = 5;
   localparam int unsigned FRAME_BITS = 8;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
      StParity = 3'd3,
      StStop   = 3'd4
   } tx_state_t;

   // lvl occupies the upper bits so the packed word reads {lvl, l}; l goes out first.
   typedef struct packed {
      logic [3:0] lvl;
      logic       l;
   } alert_status_t;

   function automatic logic even_parity(input alert_status_t s);
      return ^s;
   endfunction

endpackage

// File: rtl/alert_bit_timer.sv
// Bit-period timer: tick marks the final clock cycle of each serial bit.
// CLKS_PER_BIT must be at least 2.
module alert_bit_timer #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic tick
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   // Count while running, wrap at the last cycle of the bit, hold at zero when idle.
   always_comb begin
      cnt_d = cnt_q + CntW'(1);
      if (!run || (cnt_q == LastCnt)) begin
         cnt_d = '0;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = run && (cnt_q == LastCnt);

endmodule

// File: rtl/alert_status_tx.sv
// Serialises the alert-panel lamp status as start, 5 data bits (LSB first),
// even parity and stop, on request or automatically when the status changes.
module alert_status_tx
   import alert_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter bit          AUTO_SEND    = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       send,
   input  logic       l,
   input  logic [3:0] lvl,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   tx_state_t           state_q;
   alert_status_t       status;
   alert_status_t       last_sent_q;
   logic [STATUS_W-1:0] shift_q;
   logic                parity_q;
   logic [2:0]          idx_q;
   logic                tx_q;
   logic                busy_q;
   logic                done_q;
   logic                run;
   logic                bit_tick;
   logic                start_req;

   // Assemble the live status word and decide whether an idle cycle launches a frame.
   always_comb begin
      status.lvl = lvl;
      status.l   = l;
      start_req  = send || (AUTO_SEND && (status != last_sent_q));
   end

   assign run = (state_q != StIdle);

   alert_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk  (clk),
      .rst  (rst),
      .run  (run),
      .tick (bit_tick)
   );

   // Frame FSM; tx, busy and done are all flops so the line never glitches.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         last_sent_q <= '0;
         shift_q     <= '0;
         parity_q    <= 1'b0;
         idx_q       <= '0;
         tx_q        <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start_req) begin
                  state_q     <= StStart;
                  shift_q     <= status;
                  last_sent_q <= status;
                  parity_q    <= even_parity(status);
                  idx_q       <= '0;
                  tx_q        <= 1'b0;
                  busy_q      <= 1'b1;
               end
            end
            StStart: begin
               if (bit_tick) begin
                  state_q <= StData;
                  idx_q   <= '0;
                  tx_q    <= shift_q[0];
               end
            end
            StData: begin
               if (bit_tick) begin
                  if (idx_q == 3'(STATUS_W - 1)) begin
                     state_q <= StParity;
                     tx_q    <= parity_q;
                  end else begin
                     idx_q   <= idx_q + 3'd1;
                     shift_q <= shift_q >> 1;
                     tx_q    <= shift_q[1];
                  end
               end
            end
            StParity: begin
               if (bit_tick) begin
                  state_q <= StStop;
                  tx_q    <= 1'b1;
               end
            end
            StStop: begin
               if (bit_tick) begin
                  state_q <= StIdle;
                  tx_q    <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= StIdle;
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign tx   = tx_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule
